// File: rtl/bbs_pkg.sv
// Shared constants, state type and reduction step for the Blum Blum Shub sequencer.
package bbs_pkg;

  localparam logic [63:0] BBS_P       = 64'd2147483647;
  localparam logic [63:0] BBS_Q       = 64'd2147483629;
  localparam logic [63:0] BBS_N       = 64'h3FFF_FFF6_0000_0013;
  localparam int          REDUCER_LAT = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQUARE,
    S_REDUCE,
    S_EMIT,
    S_HOLD
  } state_t;

  // One restoring step: bring in the next dividend bit, subtract N if it fits.
  // rem < N < 2^62, so the shifted value never overflows 64 bits.
  function automatic logic [63:0] mod_step(input logic [63:0] rem, input logic b);
    logic [63:0] t;
    t = (rem << 1) | {63'd0, b};
    return (t >= BBS_N) ? (t - BBS_N) : t;
  endfunction

endpackage

// File: rtl/bbs_mod_reducer.sv
// 128-bit -> 64-bit modular reducer (mod BBS_N), one dividend bit per cycle.
// start sampled in cycle 0, done pulses in cycle REDUCER_LAT with the result.
module bbs_mod_reducer
  import bbs_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_start,
  input  logic [127:0] i_a,
  output logic         o_done,
  output logic [63:0]  o_result
);

  logic         r_busy;
  logic         r_done;
  logic [6:0]   r_cnt;
  logic [127:0] r_div;
  logic [63:0]  r_rem;

  // The top dividend bit is consumed on the start edge, leaving 127 busy steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_div  <= '0;
      r_rem  <= '0;
    end else if (i_clear) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= mod_step(64'd0, i_a[127]);
        r_div  <= {i_a[126:0], 1'b0};
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= mod_step(r_rem, r_div[127]);
        r_div <= {r_div[126:0], 1'b0};
        r_cnt <= r_cnt + 7'd1;
        if (r_cnt == 7'(REDUCER_LAT - 2)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done   = r_done;
  assign o_result = r_rem;

endmodule

// File: rtl/bbs_sequencer.sv
// Blum Blum Shub controller: seed load, square/reduce recurrence, bit packing.
// Optional seed range check enabled by defining BBS_SEQ_SEED_CHECK_EN.
module bbs_sequencer
  import bbs_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_seed_valid,
  input  logic [63:0]      i_seed,
  output logic             o_seed_ready,
  output logic             o_seed_err,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [OUT_W-1:0] o_out_data,
  output logic             o_busy
);

  localparam int CW = $clog2(OUT_W + 1);

  state_t           r_state, w_next;
  logic [63:0]      r_x;
  logic [127:0]     r_prod;
  logic [OUT_W-1:0] r_word;
  logic [CW-1:0]    r_cnt;
  logic             r_init;
  logic             r_start;
  logic             w_red_start;
  logic             w_done;
  logic [63:0]      w_result;
  logic             w_seed_bad;

`ifdef BBS_SEQ_SEED_CHECK_EN
  logic r_seed_err;
  assign w_seed_bad = (i_seed < 64'd2) || (i_seed >= BBS_N);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_seed_err <= 1'b0;
    else     r_seed_err <= !i_clear && (r_state == S_IDLE) && i_seed_valid && w_seed_bad;
  end
  assign o_seed_err = r_seed_err;
`else
  assign w_seed_bad = 1'b0;
  assign o_seed_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_seed_valid && !w_seed_bad) w_next = S_SQUARE;
      S_SQUARE: w_next = S_REDUCE;
      S_REDUCE: if (w_done) w_next = r_init ? S_SQUARE : S_EMIT;
      S_EMIT:   w_next = (r_cnt == CW'(OUT_W - 1)) ? S_HOLD : S_SQUARE;
      S_HOLD:   if (i_out_ready) w_next = S_SQUARE;
      default:  w_next = S_IDLE;
    endcase
    if (i_clear) w_next = S_IDLE;
  end

  always_comb begin
    o_seed_ready = (r_state == S_IDLE);
    o_busy       = (r_state != S_IDLE);
    o_out_valid  = (r_state == S_HOLD);
  end

  // r_start is high exactly in the REDUCE entry cycle, since SQUARE always
  // hands over to REDUCE unless cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_prod  <= '0;
      r_word  <= '0;
      r_cnt   <= '0;
      r_init  <= 1'b0;
      r_start <= 1'b0;
    end else if (i_clear) begin
      r_word  <= '0;
      r_cnt   <= '0;
      r_init  <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_start <= (r_state == S_SQUARE);
      case (r_state)
        S_IDLE: if (i_seed_valid && !w_seed_bad) begin
          r_x    <= i_seed;
          r_init <= 1'b1;
          r_cnt  <= '0;
          r_word <= '0;
        end
        S_SQUARE: r_prod <= 128'(r_x) * 128'(r_x);
        S_REDUCE: if (w_done) begin
          r_x    <= w_result;
          r_init <= 1'b0;
        end
        S_EMIT: begin
          r_word <= r_word | (OUT_W'(r_x[0]) << r_cnt);
          r_cnt  <= r_cnt + CW'(1);
        end
        S_HOLD: if (i_out_ready) begin
          r_cnt  <= '0;
          r_word <= '0;
        end
        default: ;
      endcase
    end
  end

  assign w_red_start = r_start;
  assign o_out_data  = r_word;

  bbs_mod_reducer u_red (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (i_clear),
    .i_start  (w_red_start),
    .i_a      (r_prod),
    .o_done   (w_done),
    .o_result (w_result)
  );

endmodule

// File: tb/tb_bbs_sequencer.sv
// Self-checking bench for bbs_sequencer built with OUT_W=4.
module tb_bbs_sequencer;
  import bbs_pkg::*;

  localparam int W     = 4;
  localparam int WP    = W * 131 + 1;
  localparam int FIRST = (W + 1) * 131;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_clear = 1'b0;
  logic         i_seed_valid = 1'b0;
  logic [63:0]  i_seed = '0;
  logic         i_out_ready = 1'b0;
  logic         o_seed_ready, o_seed_err, o_out_valid, o_busy;
  logic [W-1:0] o_out_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;
  int start_cnt = 0;
  int t0 = 0;

  typedef struct {
    logic [63:0]  seed;
    logic [W-1:0] word;
    int           first;
  } vec_t;
  vec_t tbl[$];

  bbs_sequencer #(.OUT_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (i_clear),
    .i_seed_valid (i_seed_valid),
    .i_seed       (i_seed),
    .o_seed_ready (o_seed_ready),
    .o_seed_err   (o_seed_err),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_data   (o_out_data),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(posedge clk) if (dut.w_red_start) start_cnt <= start_cnt + 1;

  // Reference: x_{k+1} = x_k^2 mod N with wide arithmetic.
  function automatic logic [63:0] f_next(input logic [63:0] x);
    logic [127:0] sq;
    sq = {64'd0, x} * {64'd0, x};
    return 64'(sq % {64'd0, BBS_N});
  endfunction

  task automatic model_word(inout logic [63:0] x, output logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      x    = f_next(x);
      w[i] = x[0];
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  task automatic offer(input logic [63:0] s);
    i_seed       = s;
    i_seed_valid = 1'b1;
    t0           = cyc_cnt;
    @(negedge clk);
    i_seed_valid = 1'b0;
  endtask

  task automatic wait_valid(output int at);
    int n;
    n = 0;
    while (!o_out_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!o_out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid: got timeout expected out_valid");
    end
    at = cyc_cnt;
  endtask

  task automatic accept();
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
  endtask

  initial begin
    int           at, at2, c, errs, s0, k;
    logic [63:0]  x, sd;
    logic [W-1:0] w1, w2;

    repeat (3) @(negedge clk);
    chk("rst_seed_ready", o_seed_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_data", o_out_data, 0);
    chk("rst_seed_err", o_seed_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Async reset in the middle of a reduction.
    offer(64'd3);
    repeat (60) @(negedge clk);
    chk("mid_busy", o_busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_ready", o_seed_ready, 1);
    chk("mid_rst_valid", o_out_valid, 0);
    chk("mid_rst_data", o_out_data, 0);
    chk("mid_rst_x", dut.r_x, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", o_seed_ready, 1);
    chk("post_rst_busy", o_busy, 0);

`ifdef BBS_SEQ_SEED_CHECK_EN
    begin
      logic [63:0] bad [3];
      bad = '{64'd0, 64'd1, BBS_N};
      for (int i = 0; i < 3; i++) begin
        offer(bad[i]);
        chk("rej_err", o_seed_err, 1);
        chk("rej_busy", o_busy, 0);
        @(negedge clk);
        chk("rej_err_pulse", o_seed_err, 0);
        chk("rej_ready", o_seed_ready, 1);
      end
      offer(BBS_N - 64'd1);
      chk("acc_busy", o_busy, 1);
      chk("acc_err", o_seed_err, 0);
      do_clear();
    end
`else
    offer(64'd0);
    chk("nochk_err", o_seed_err, 0);
    chk("nochk_busy", o_busy, 1);
    do_clear();
    tbl.push_back('{64'd0, 4'h0, FIRST});
    tbl.push_back('{64'd1, 4'hF, FIRST});
`endif

    tbl.push_back('{64'd3, 4'hF, FIRST});
    tbl.push_back('{64'd2, 4'h0, FIRST});

    foreach (tbl[i]) begin
      do_clear();
      x = f_next(tbl[i].seed);
      model_word(x, w1);
      model_word(x, w2);
      offer(tbl[i].seed);
      wait_valid(at);
      chk("tbl_first_cycle", 64'(at - t0), 64'(tbl[i].first));
      chk("tbl_word", o_out_data, tbl[i].word);
      accept();
      wait_valid(at2);
      chk("tbl_period", 64'(at2 - at), 64'(WP));
      chk("tbl_word2", o_out_data, w2);
      accept();
    end

    // Back-pressure: word held 1000 cycles, recurrence stalled.
    do_clear();
    x = f_next(64'd3);
    model_word(x, w1);
    model_word(x, w2);
    offer(64'd3);
    wait_valid(at);
    chk("bp_word1", o_out_data, w1);
    s0   = start_cnt;
    errs = 0;
    repeat (1000) begin
      @(negedge clk);
      if (o_out_data !== w1 || o_busy !== 1'b1 || o_out_valid !== 1'b1) errs++;
    end
    chk("bp_hold_errs", 64'(errs), 0);
    chk("bp_starts", 64'(start_cnt - s0), 0);
    c = cyc_cnt;
    accept();
    wait_valid(at);
    chk("bp_period", 64'(at - c), 64'(WP));
    chk("bp_word2", o_out_data, w2);

    // clear wins over a simultaneous output handshake.
    i_clear     = 1'b1;
    i_out_ready = 1'b1;
    @(negedge clk);
    i_clear     = 1'b0;
    i_out_ready = 1'b0;
    chk("clr_hs_valid", o_out_valid, 0);
    chk("clr_hs_busy", o_busy, 0);
    chk("clr_hs_ready", o_seed_ready, 1);
    offer(64'd3);
    wait_valid(at);
    chk("clr_hs_first", 64'(at - t0), 64'(FIRST));
    chk("clr_hs_word", o_out_data, 4'hF);
    accept();

    // clear in the middle of a reduction; no stale done may shorten the next one.
    do_clear();
    offer(64'd2);
    repeat (200) @(negedge clk);
    do_clear();
    chk("clr_red_busy", o_busy, 0);
    offer(64'd3);
    wait_valid(at);
    chk("clr_red_first", 64'(at - t0), 64'(FIRST));
    chk("clr_red_word", o_out_data, 4'hF);
    accept();

    // Random seeds against the reference, with random consumer stalls.
    for (int r = 0; r < 3; r++) begin
      do_clear();
      sd = {$urandom, $urandom};
      sd = (sd % (BBS_N - 64'd2)) + 64'd2;
      x  = f_next(sd);
      offer(sd);
      for (int wd = 0; wd < 2; wd++) begin
        model_word(x, w1);
        wait_valid(at);
        chk("rnd_word", o_out_data, w1);
        k = $urandom_range(0, 5);
        repeat (k) @(negedge clk);
        chk("rnd_word_held", o_out_data, w1);
        accept();
      end
    end

    do_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bbs_sequencer.md
# bbs_sequencer

Control block for the Blum Blum Shub generator. It accepts a 64-bit seed, runs the square-then-reduce-mod-N recurrence by sequencing a 128×→64-bit modular reducer, and harvests one output bit per step. It packs the bits into OUT_W-bit words delivered over a valid/ready stream. It sits between the seed source (host/UART loader) and the random-word consumer.

## Interface
- OUT_W, 32, output word width in bits (1..64)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous abort to IDLE, any state
- seed_valid  in  1  seed offer
- seed  in  64  seed value
- seed_ready  out  1  high only in IDLE
- seed_err  out  1  one-cycle pulse: offered seed rejected
- out_valid  out  1  out_data holds a full word
- out_ready  in  1  consumer accepts word
- out_data  out  OUT_W  packed bits; first-generated bit in bit 0
- busy  out  1  high in every state except IDLE

## Operation
- Modulus N = p·q, p = 2147483647, q = 2147483629; N = 64'h3FFF_FFF6_0000_0013.
- States: IDLE, SQUARE, REDUCE, EMIT, HOLD.
- IDLE: seed_ready=1. On seed_valid, the handshake is checked (see Configuration). If accepted: x←seed, init←1, bit count←0, go to SQUARE.
- SQUARE: prod←x·x as a full 128-bit unsigned product, registered. Go to REDUCE.
- REDUCE: drive reducer start=1 with a=prod in the entry cycle only. Wait for reducer done, then x←result.
  - If init=1: clear init and go to SQUARE. This makes x0 = seed² mod N, with no bit emitted.
  - Otherwise go to EMIT.
- EMIT: shift x[0] into word bit position count, then count++.
  - If count reaches OUT_W: go to HOLD.
  - Otherwise go to SQUARE.
- HOLD: out_valid=1, out_data stable. On out_ready, count←0 and go to SQUARE. The recurrence stalls while HOLD waits.
- clear (any state): next state IDLE; out_valid←0; partial word discarded. The reducer is sync-cleared, so no stale done is seen later. clear wins over every simultaneous event.
- seed_valid outside IDLE is ignored; seed_ready=0 there.
- Reset values: out_valid=0, out_data=0, seed_ready=1, seed_err=0, busy=0, state IDLE, x=0.
- rst mid-operation: all state returns to reset values immediately; the reducer is reset as well.

## Timing
- Reducer contract: start sampled in cycle 0; done pulses in cycle 128 with result valid in the same cycle. REDUCE therefore lasts 129 cycles.
- One bit costs 131 cycles (SQUARE 1 + REDUCE 129 + EMIT 1).
- Seed handshake edge = cycle 0. SQUARE runs in cycle 1. out_valid first rises in cycle (OUT_W+1)·131.
- With out_ready held high, HOLD lasts 1 cycle. Word period is OUT_W·131+1 cycles.
- seed_err pulses in the cycle after the rejected handshake. The block stays in IDLE.

## Configuration
- BBS_SEQ_SEED_CHECK_EN defined: a seed < 2 or ≥ N is rejected.
  - The handshake completes (seed_ready=1).
  - seed_err pulses, and state stays IDLE.
- Undefined: every seed is accepted. seed_err is tied 0. Seed 0/1 produce an all-zero/all-one stream; that is the accepted consequence.

## Structure
- Shared package bbs_pkg holds:
  - BBS_P, BBS_Q, BBS_N constants
  - state enum type
  - REDUCER_LAT = 128
- Sub-module bbs_mod_reducer implements the start/done/clear contract above. It is a restoring shift-subtract reducer handling one dividend bit per cycle. The controller depends only on that contract, not on the reducer's internals.

## Test plan
- Reset check: assert rst mid-REDUCE → all outputs at reset values; seed_ready=1 the cycle after release.
- Build OUT_W=4, seed=3:
  - x1..x4 = 81, 6561, 43046721, 1853020188851841.
  - out_data = 4'hF; out_valid rises at cycle 655.
- Build OUT_W=4, seed=2:
  - x1..x4 = 16, 256, 65536, 2^32.
  - out_data = 4'h0. Next x5 = 171798691764.
- Back-pressure: hold out_ready=0 for 1000 cycles → out_data stable, busy=1, reducer start never asserted; release → next word valid OUT_W·131+1 cycles after the handshake.
- With BBS_SEQ_SEED_CHECK_EN: seeds 0, 1 and 64'h3FFF_FFF6_0000_0013 → seed_err pulse each, busy stays 0. Seed N−1 is accepted.
- Edge conditions:
  - clear asserted together with out_valid·out_ready → IDLE, out_valid=0.
  - A fresh seed afterwards restarts the sequence from its own x0; first word timing matches (OUT_W+1)·131.
